ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// The host inhibits the bus by pulling the clock low, then issues a request to
// send. It shifts out 8 data bits (LSB first), an odd parity bit and a released
// stop bit on the device's falling clock edges, and then checks the device ACK.
// Ports:
//   reloj        system clock; all logic runs on its rising edge
//   reset        asynchronous, active-high reset
//   tx_data      command byte, captured on tx_start while idle
//   tx_start     one-cycle send request (ignored while busy)
//   ps2_clk_in   PS/2 clock pad input (asynchronous)
//   ps2_data_in  PS/2 data pad input (asynchronous)
//   ps2_clk_oe   1 = pull the PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull the PS/2 data low, 0 = release
//   busy         high from request capture until return to idle
//   done         one-cycle pulse: frame sent and ACK received
//   err          one-cycle pulse: missing ACK or clock timeout
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic             clk_prev_q, clk_prev_d;
  logic [8:0]       frame_q, frame_d;
  logic [3:0]       idx_q, idx_d;
  logic             drv_q, drv_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_s, data_s, fall, to_expired;

  assign clk_s      = clk_sync_q[1];
  assign data_s     = data_sync_q[1];
  assign fall       = clk_prev_q & ~clk_s;
  assign to_expired = (to_q == TO_LAST) && !fall;

  // State register. Synchronizers reset to the idle (high) bus level so that
  // leaving reset never manufactures a falling edge.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      frame_q     <= '0;
      idx_q       <= '0;
      drv_q       <= 1'b0;
      inh_q       <= '0;
      to_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      drv_q       <= drv_d;
      inh_q       <= inh_d;
      to_q        <= to_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic. done/err are registered together with the return to
  // idle, so busy falls in the same cycle the pulse is visible.
  always_comb begin
    state_d     = state_q;
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_prev_d  = clk_s;
    frame_d     = frame_q;
    idx_d       = idx_q;
    drv_d       = drv_q;
    inh_d       = inh_q;
    to_d        = to_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // Edge-to-edge watchdog; saturates at the terminal value.
    if (state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
      if (fall) begin
        to_d = '0;
      end else if (to_q != TO_W'(TIMEOUT_CYCLES)) begin
        to_d = to_q + TO_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        drv_d = 1'b0;
        inh_d = '0;
        to_d  = '0;
        if (tx_start) begin
          frame_d = {~^tx_data, tx_data};
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          state_d = ST_REQ;
        end else begin
          inh_d = inh_q + INH_W'(1);
        end
      end
      ST_REQ: begin
        // Start bit stays asserted through SHIFT until the first falling edge.
        drv_d   = 1'b1;
        idx_d   = '0;
        to_d    = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (to_expired) begin
          drv_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (fall) begin
          if (idx_q == 4'd9) begin
            drv_d   = 1'b0;
            state_d = ST_ACK;
          end else begin
            drv_d = ~frame_q[idx_q];
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_ACK: begin
        if (to_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (fall) begin
          if (!data_s) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so reset releases the lines at once.
  always_comb begin
    ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
    ps2_data_oe = (state_q == ST_REQ) || ((state_q == ST_SHIFT) && drv_q);
    busy        = (state_q != ST_IDLE);
    done        = done_q;
    err         = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model clocks frames out of the host
// while a scoreboard checks each done/err pulse against queued expectations.
module tb_ps2_host_tx;

  localparam int unsigned TO_CYC = 300;
  localparam int unsigned HALF   = 20;

  logic       reloj = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain bus with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(5000), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .reloj(reloj), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .err(err)
  );

  always #10 reloj = ~reloj;

  typedef struct {
    bit         is_done;
    bit         chk_bits;
    logic [9:0] bits;     // {stop, parity, data[7:0]} as seen on the line
    bit         chk_to;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_m;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned last_fall_cyc = 0;
  logic [9:0]  cap_bits = '0;
  bit          pulse_prev = 1'b0;

  always @(posedge reloj) begin
    cyc <= cyc + 1;
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycle %0d reached, required < 90000", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge reloj);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge reloj) begin
    if (pulse_prev) chk("pulse_width", {30'd0, done, err}, 32'd0);
    pulse_prev = 1'b0;
    if (!reset && (done || err)) begin
      pulse_prev = 1'b1;
      chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b required no pulse", done, err);
      end else begin
        e_m = exp_q.pop_front();
        chk("outcome_done", {31'd0, done}, {31'd0, e_m.is_done});
        chk("busy_at_end", {31'd0, busy}, 32'd0);
        chk("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        if (e_m.chk_bits) chk("frame_bits", {22'd0, cap_bits}, {22'd0, e_m.bits});
        // Two synchronizer stages plus the counter-clear register precede the count.
        if (e_m.chk_to) chk("timeout_latency", cyc - last_fall_cyc, TO_CYC + 3);
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit push, input exp_t e);
    tick(1);
    tx_data  = d;
    tx_start = 1'b1;
    if (push) exp_q.push_back(e);
    tick(1);
    tx_start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Device model: waits for request-to-send, then generates n_edges clocks,
  // sampling the data line just before each rising edge.
  task automatic dev(input int unsigned n_edges, input bit ack_low);
    int unsigned k = 0;
    cap_bits = '0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && k < 20000) begin
      tick(1);
      k++;
    end
    if (k >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL rts_wait: got no request-to-send within %0d cycles, required one", k);
      return;
    end
    tick(HALF);
    for (int unsigned e = 1; e <= n_edges; e++) begin
      dev_data_low  = (e == 11) && ack_low;
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      tick(HALF);
      if (e <= 10) cap_bits[e-1] = ps2_data_in;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      tick(HALF);
    end
  endtask

  task automatic drain();
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      tick(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending results after %0d cycles, required 0", exp_q.size(), k);
      exp_q.delete();
    end
    tick(5);
  endtask

  function automatic exp_t mk(input bit d, input bit cb, input logic [9:0] b, input bit ct);
    exp_t e;
    e.is_done  = d;
    e.chk_bits = cb;
    e.bits     = b;
    e.chk_to   = ct;
    return e;
  endfunction

  initial begin
    int unsigned cnt;
    tick(5);
    chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    tick(3);

    // 0xED: six ones -> parity 1; first request after reset.
    send(8'hED, 1'b1, mk(1'b1, 1'b1, 10'h3ED, 1'b0));
    dev(11, 1'b1);
    drain();
    chk("busy_idle_after_ed", {31'd0, busy}, 32'd0);

    // 0x01 -> parity 0; 0x00 -> parity 1.
    send(8'h01, 1'b1, mk(1'b1, 1'b1, 10'h201, 1'b0));
    dev(11, 1'b1);
    drain();
    send(8'h00, 1'b1, mk(1'b1, 1'b1, 10'h300, 1'b0));
    dev(11, 1'b1);
    drain();

    // 0xFF -> parity 1, with clock-inhibit length measured and a second
    // request issued mid-inhibit that must not disturb the frame.
    send(8'hFF, 1'b1, mk(1'b1, 1'b1, 10'h3FF, 1'b0));
    cnt = 0;
    for (int unsigned k = 0; k < 12000; k++) begin
      if (ps2_clk_oe) cnt++;
      else if (cnt > 0) break;
      if (k == 50) chk("inhibit_data_released", {31'd0, ps2_data_oe}, 32'd0);
      tx_start = (k == 100);
      tx_data  = (k == 100) ? 8'h00 : 8'hFF;
      tick(1);
    end
    tx_start = 1'b0;
    chk("inhibit_length", cnt, 32'd5001);
    dev(11, 1'b1);
    drain();

    // Device leaves data high at the ACK slot -> err. 0x5A: four ones -> parity 1.
    send(8'h5A, 1'b1, mk(1'b0, 1'b1, 10'h35A, 1'b0));
    dev(11, 1'b0);
    drain();

    // Device stops after 4 edges -> timeout err.
    send(8'h3C, 1'b1, mk(1'b0, 1'b0, 10'h000, 1'b1));
    dev(4, 1'b1);
    drain();

    // Reset during SHIFT at index 5: bit4 of 0x00 is 0, so data is driven low.
    send(8'h00, 1'b0, mk(1'b0, 1'b0, 10'h000, 1'b0));
    dev(5, 1'b1);
    chk("pre_reset_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("reset_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    tick(4);
    reset = 1'b0;
    tick(3);

    // 0xF4: five ones -> parity 0.
    send(8'hF4, 1'b1, mk(1'b1, 1'b1, 10'h2F4, 1'b0));
    dev(11, 1'b1);
    drain();
    chk("busy_idle_final", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
